sram_scheduler: RTL and testbench



---
 rtl/sram_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_sram_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_scheduler.sv
// Record/play sequencer and request arbiter for the single-port audio SRAM.
// Owns the mode FSM, the record/play pointers and the recorded length.
module sram_scheduler #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic              record_btn,
  input  logic [3:0]        step,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   rec_len
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W-1:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_RECORD = 2'd1,
    M_PLAY   = 2'd2,
    M_PAUSE  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    A_IDLE,
    A_W1,
    A_W2,
    A_R1,
    A_R2,
    A_RDONE,
    A_WDROP,
    A_RDROP
  } acc_t;

  mode_t            mode_q;
  acc_t             acc_q;
  logic [PTR_W-1:0] rec_ptr;
  logic [PTR_W-1:0] play_ptr;
  logic             last_wr;

  logic             wr_count;
  logic             rd_count;
  logic             grant_wr;
  logic [3:0]       step_eff;
  logic [PTR_W-1:0] rec_ptr_inc;
  logic [PTR_W-1:0] play_ptr_inc;

  // A completion only advances its pointer if the mode still owns it.
  assign wr_count     = (acc_q == A_W1) && (mode_q == M_RECORD);
  assign rd_count     = (acc_q == A_R2) && (mode_q == M_PLAY);
  assign step_eff     = (step == 4'd0) ? 4'd1 : step;
  assign rec_ptr_inc  = rec_ptr + PTR_W'(wr_count);
  assign play_ptr_inc = rd_count ? play_ptr + PTR_W'(step_eff) : play_ptr;
  assign grant_wr     = wr_req && (!rd_req || !last_wr);

  assign mode = mode_q;

  // Mode FSM, pointers and recorded length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= M_IDLE;
      rec_ptr  <= '0;
      play_ptr <= '0;
      rec_len  <= '0;
    end else begin
      rec_ptr  <= rec_ptr_inc;
      play_ptr <= play_ptr_inc;
      unique case (mode_q)
        M_IDLE: begin
          if (record_btn) begin
            mode_q  <= M_RECORD;
            rec_ptr <= '0;
          end else if (play_btn && rec_len != '0) begin
            mode_q   <= M_PLAY;
            play_ptr <= '0;
          end
        end
        M_RECORD: begin
          if (record_btn) begin
            mode_q  <= M_IDLE;
            rec_len <= rec_ptr_inc;
          end else if (wr_count && rec_ptr == LAST_ADDR) begin
            mode_q  <= M_IDLE;
            rec_len <= DEPTH;
          end
        end
        M_PLAY: begin
          if (record_btn) begin
            mode_q <= M_IDLE;
          end else if (acc_q == A_RDONE && play_ptr >= rec_len) begin
            mode_q <= M_IDLE;
          end else if (play_btn) begin
            mode_q <= M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (record_btn) begin
            mode_q <= M_IDLE;
          end else if (play_btn) begin
            mode_q <= M_PLAY;
          end
        end
        default: mode_q <= M_IDLE;
      endcase
    end
  end

  // Access FSM: arbitration and SRAM strobe sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= A_IDLE;
      last_wr    <= 1'b0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      unique case (acc_q)
        A_IDLE: begin
          if (grant_wr) begin
            last_wr <= 1'b1;
            if (mode_q == M_RECORD) begin
              acc_q      <= A_W1;
              sram_addr  <= rec_ptr[ADDR_W-1:0];
              sram_dq_o  <= wr_data;
              sram_ce_n  <= 1'b0;
              sram_we_n  <= 1'b0;
              sram_ub_n  <= 1'b0;
              sram_lb_n  <= 1'b0;
              sram_dq_oe <= 1'b1;
            end else begin
              acc_q  <= A_WDROP;
              wr_ack <= 1'b1;
            end
          end else if (rd_req) begin
            last_wr <= 1'b0;
            if (mode_q == M_PLAY) begin
              acc_q     <= A_R1;
              sram_addr <= play_ptr[ADDR_W-1:0];
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_ub_n <= 1'b0;
              sram_lb_n <= 1'b0;
            end else begin
              acc_q    <= A_RDROP;
              rd_valid <= 1'b1;
              rd_data  <= '0;
            end
          end
        end
        A_W1: begin
          acc_q     <= A_W2;
          sram_we_n <= 1'b1;
          wr_ack    <= 1'b1;
        end
        A_W2: begin
          acc_q      <= A_IDLE;
          sram_ce_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        A_R1: acc_q <= A_R2;
        A_R2: begin
          acc_q     <= A_RDONE;
          rd_data   <= sram_dq_i;
          rd_valid  <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
        end
        // Hold-off cycle so a requester still high during its ack is not regranted.
        A_RDONE, A_WDROP, A_RDROP: acc_q <= A_IDLE;
        default: acc_q <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_scheduler.sv
// Bench for sram_scheduler: vector table, corner sequences and a randomized
// run against a transaction-level model, with a behavioural SRAM attached.
module tb_sram_scheduler;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int OP_REC = 0, OP_PLAY = 1, OP_BOTH = 2, OP_WR = 3, OP_RD = 4, OP_WAIT = 5;

  logic          clk, reset, play_btn, record_btn;
  logic [3:0]    step;
  logic          wr_req, wr_ack, rd_req, rd_valid;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic [1:0]    mode;
  logic [AW:0]   rec_len;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  int sram_reads = 0;

  logic [DW-1:0] mem [16];

  typedef struct {
    int          op;
    logic [15:0] data;
    logic [3:0]  st;
    logic [15:0] exp_data;
    int          exp_lat;
    logic [1:0]  exp_mode;
    logic [4:0]  exp_len;
  } vec_t;

  vec_t vt[$];

  sram_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .play_btn(play_btn), .record_btn(record_btn),
    .step(step), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .mode(mode), .rec_len(rec_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: written on the edge closing a we_n-low cycle.
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_we_n && !sram_oe_n) viol++;
      if (!sram_oe_n && sram_dq_oe) viol++;
      if (sram_ub_n != sram_ce_n || sram_lb_n != sram_ce_n) viol++;
      if (!sram_ce_n && !sram_oe_n) sram_reads++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic p);
    record_btn = r;
    play_btn   = p;
    tick();
    record_btn = 1'b0;
    play_btn   = 1'b0;
    tick();
  endtask

  // One transaction; lat counts clock edges from raising req to seeing ack/valid.
  task automatic run_op(input int op, input logic [15:0] d, input logic [3:0] st,
                        output logic [15:0] rdat, output int lat);
    step = st;
    rdat = '0;
    lat  = 0;
    case (op)
      OP_REC:  press(1'b1, 1'b0);
      OP_PLAY: press(1'b0, 1'b1);
      OP_BOTH: press(1'b1, 1'b1);
      OP_WAIT: repeat (20) tick();
      OP_WR: begin
        wr_data = d;
        wr_req  = 1'b1;
        while (!wr_ack && lat < 12) begin
          tick();
          lat++;
        end
        wr_req = 1'b0;
        tick();
      end
      OP_RD: begin
        rd_req = 1'b1;
        while (!rd_valid && lat < 12) begin
          tick();
          lat++;
        end
        rdat   = rd_data;
        rd_req = 1'b0;
        tick();
      end
      default: tick();
    endcase
  endtask

  function automatic vec_t mk(int op, int d, int st, int ed, int el, int em, int len);
    vec_t v;
    v.op       = op;
    v.data     = 16'(d);
    v.st       = 4'(st);
    v.exp_data = 16'(ed);
    v.exp_lat  = el;
    v.exp_mode = 2'(em);
    v.exp_len  = 5'(len);
    return v;
  endfunction

  logic [15:0] rdat;
  int          lat;

  initial begin
    logic ev[$];
    int   nw, rd0, ticks;
    int   m_mode, m_rec_ptr, m_play_ptr, m_len, exp_lat, op, r;
    logic [15:0] exp_mem [16];
    logic [15:0] d, exp_d;
    logic [3:0]  st;

    reset = 1'b1; play_btn = 1'b0; record_btn = 1'b0; step = 4'd1;
    wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    repeat (3) tick();
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    check("rst_outs", 32'({wr_ack, rd_valid, sram_dq_oe, mode}), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_rec_len", 32'(rec_len), 32'h0);
    check("rst_data", 32'({rd_data, sram_dq_o}), 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);

    // Reset landing in W1 must abort the strobes at once and never ack.
    press(1'b1, 1'b0);
    wr_data = 16'h7777;
    wr_req  = 1'b1;
    tick();
    check("w1_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}), 32'b0011);
    #2 reset = 1'b1;
    #1;
    check("rstw1_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    check("rstw1_dq_oe_mode", 32'({sram_dq_oe, mode}), 32'h0);
    wr_req = 1'b0;
    tick();
    check("rstw1_no_ack_a", 32'(wr_ack), 32'h0);
    reset = 1'b0;
    tick();
    check("rstw1_no_ack_b", 32'(wr_ack), 32'h0);

    // op, data, step, exp_data, exp_lat, exp_mode, exp_len
    vt.push_back(mk(OP_PLAY, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(OP_REC,  0, 1, 0, 0, 1, 0));
    vt.push_back(mk(OP_WR, 'h1111, 1, 0, 2, 1, 0));
    vt.push_back(mk(OP_WR, 'h2222, 1, 0, 2, 1, 0));
    vt.push_back(mk(OP_WR, 'h3333, 1, 0, 2, 1, 0));
    vt.push_back(mk(OP_WR, 'h4444, 1, 0, 2, 1, 0));
    vt.push_back(mk(OP_REC,  0, 1, 0, 0, 0, 4));
    vt.push_back(mk(OP_RD,   0, 1, 0, 1, 0, 4));
    vt.push_back(mk(OP_WR, 'h5555, 1, 0, 1, 0, 4));
    vt.push_back(mk(OP_PLAY, 0, 2, 0, 0, 2, 4));
    vt.push_back(mk(OP_RD,   0, 2, 'h1111, 3, 2, 4));
    vt.push_back(mk(OP_RD,   0, 2, 'h3333, 3, 0, 4));
    vt.push_back(mk(OP_RD,   0, 2, 0, 1, 0, 4));
    vt.push_back(mk(OP_PLAY, 0, 3, 0, 0, 2, 4));
    vt.push_back(mk(OP_RD,   0, 3, 'h1111, 3, 2, 4));
    vt.push_back(mk(OP_PLAY, 0, 3, 0, 0, 3, 4));
    vt.push_back(mk(OP_WAIT, 0, 3, 0, 0, 3, 4));
    vt.push_back(mk(OP_RD,   0, 3, 0, 1, 3, 4));
    vt.push_back(mk(OP_PLAY, 0, 3, 0, 0, 2, 4));
    vt.push_back(mk(OP_RD,   0, 3, 'h4444, 3, 0, 4));
    vt.push_back(mk(OP_PLAY, 0, 0, 0, 0, 2, 4));
    vt.push_back(mk(OP_RD,   0, 0, 'h1111, 3, 2, 4));
    vt.push_back(mk(OP_RD,   0, 0, 'h2222, 3, 2, 4));
    vt.push_back(mk(OP_REC,  0, 1, 0, 0, 0, 4));
    vt.push_back(mk(OP_BOTH, 0, 1, 0, 0, 1, 4));
    vt.push_back(mk(OP_REC,  0, 1, 0, 0, 0, 0));
    vt.push_back(mk(OP_PLAY, 0, 1, 0, 0, 0, 0));

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].data, vt[i].st, rdat, lat);
      if (vt[i].op == OP_WR || vt[i].op == OP_RD)
        check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      if (vt[i].op == OP_RD)
        check($sformatf("vec%0d_data", i), 32'(rdat), 32'(vt[i].exp_data));
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vt[i].exp_mode));
      check($sformatf("vec%0d_len", i), 32'(rec_len), 32'(vt[i].exp_len));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("mem%0d", i), 32'(mem[i]), 32'(16'h1111 * (i + 1)));

    // Contention in RECORD: both requests held; grants alternate from write.
    press(1'b1, 1'b0);
    rd0 = sram_reads;
    wr_data = 16'hABCD;
    wr_req = 1'b1;
    rd_req = 1'b1;
    ticks = 0;
    nw = 0;
    while (ev.size() < 10 && ticks < 80) begin
      tick();
      ticks++;
      if (wr_ack) begin
        ev.push_back(1'b1);
        nw++;
      end
      if (rd_valid) begin
        ev.push_back(1'b0);
        check("cont_silence", 32'(rd_data), 32'h0);
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    check("cont_events", ev.size(), 10);
    foreach (ev[i]) check($sformatf("cont_alt%0d", i), 32'(ev[i]), 32'((i % 2) == 0));
    check("cont_no_sram_read", sram_reads - rd0, 0);
    press(1'b1, 1'b0);
    check("cont_rec_len", 32'(rec_len), nw);

    // Fill all 16 locations; the last write ends recording.
    press(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_op(OP_WR, 16'hF000 + 16'(i), 4'd1, rdat, lat);
      check($sformatf("full_lat%0d", i), lat, 2);
    end
    check("full_mode", 32'(mode), 32'h0);
    check("full_len", 32'(rec_len), 32'd16);
    check("full_mem15", 32'(mem[15]), 32'hF00F);
    run_op(OP_WR, 16'h1234, 4'd1, rdat, lat);
    check("full_drop_lat", lat, 1);
    check("full_drop_len", 32'(rec_len), 32'd16);
    check("full_mem0", 32'(mem[0]), 32'hF000);

    // Randomized transactions against a transaction-level model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    m_mode = 0; m_rec_ptr = 0; m_play_ptr = 0; m_len = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 99));
      st = 4'($urandom_range(0, 15));
      d  = 16'($urandom);
      op = (r < 6) ? OP_REC : (r < 14) ? OP_PLAY : (r < 16) ? OP_BOTH : (r < 58) ? OP_WR : OP_RD;
      exp_lat = 0;
      exp_d = '0;
      case (op)
        OP_REC, OP_BOTH: begin
          if (m_mode == 0) begin m_mode = 1; m_rec_ptr = 0; end
          else if (m_mode == 1) begin m_mode = 0; m_len = m_rec_ptr; end
          else m_mode = 0;
        end
        OP_PLAY: begin
          if (m_mode == 0 && m_len != 0) begin m_mode = 2; m_play_ptr = 0; end
          else if (m_mode == 2) m_mode = 3;
          else if (m_mode == 3) m_mode = 2;
        end
        OP_WR: begin
          exp_lat = (m_mode == 1) ? 2 : 1;
          if (m_mode == 1) begin
            exp_mem[m_rec_ptr] = d;
            m_rec_ptr++;
            if (m_rec_ptr == 16) begin m_mode = 0; m_len = 16; end
          end
        end
        default: begin
          exp_lat = (m_mode == 2) ? 3 : 1;
          if (m_mode == 2) begin
            exp_d = exp_mem[m_play_ptr];
            m_play_ptr += (st == 0) ? 1 : int'(st);
            if (m_play_ptr >= m_len) m_mode = 0;
          end
        end
      endcase
      run_op(op, d, st, rdat, lat);
      if (op == OP_WR || op == OP_RD) check($sformatf("rnd%0d_lat", n), lat, exp_lat);
      if (op == OP_RD) check($sformatf("rnd%0d_data", n), 32'(rdat), 32'(exp_d));
      check($sformatf("rnd%0d_mode", n), 32'(mode), m_mode);
      check($sformatf("rnd%0d_len", n), 32'(rec_len), m_len);
    end

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
